// File: rtl/square_calc.sv
// square_calc
//   Sequential integer squarer. N^2 is built as the sum of the first N odd
//   numbers (1 + 3 + ... + (2N-1)), one addition per clock. It is used to
//   regenerate a square from a computed root so the two can be cross-checked.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   valor_i   : operand N, captured only when a start is accepted
//   start_i   : request, accepted while ready_o is high (IDLE or DONE)
//   ready_o   : idle / result valid, low while computing
//   done_o    : one-cycle pulse after a new result is committed
//   square_o  : last committed N^2, held until the next commit
module square_calc #(
    parameter int ROOT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ROOT_WIDTH-1:0]     valor_i,
    input  logic                      start_i,
    output logic                      ready_o,
    output logic                      done_o,
    output logic [2*ROOT_WIDTH-1:0]   square_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ROOT_WIDTH-1:0]   cnt;   // additions still to perform
    logic [ROOT_WIDTH:0]     odd;   // next odd number to add
    logic [2*ROOT_WIDTH-1:0] acc;   // running partial sum

    // A start is taken in DONE as well as IDLE so a held start runs
    // back to back without an extra idle cycle.
    logic accept;
    assign accept = start_i && (state == IDLE || state == DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = CALC;
            CALC:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = start_i ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status decoded from state only, no path from start_i
    assign ready_o = (state != CALC);
    assign done_o  = (state == DONE);

    // Datapath. square_o is written only on the commit cycle so partial
    // sums never become visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            odd      <= (ROOT_WIDTH+1)'(1);
            acc      <= '0;
            square_o <= '0;
        end else if (accept) begin
            cnt <= valor_i;
            odd <= (ROOT_WIDTH+1)'(1);
            acc <= '0;
        end else if (state == CALC) begin
            if (cnt != '0) begin
                acc <= acc + (2*ROOT_WIDTH)'(odd);
                odd <= odd + (ROOT_WIDTH+1)'(2);
                cnt <= cnt - ROOT_WIDTH'(1);
            end else begin
                square_o <= acc;
            end
        end
    end

endmodule

// File: tb/tb_square_calc.sv
module tb_square_calc;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start_i = 1'b0;
    logic [W-1:0]   valor_i = '0;
    logic           ready_o;
    logic           done_o;
    logic [2*W-1:0] square_o;

    square_calc #(.ROOT_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .valor_i  (valor_i),
        .start_i  (start_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .square_o (square_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [2*W-1:0] last_sq = '0;   // model of the committed result

    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0]   n;
        logic [2*W-1:0] sq;
        int             busy;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: N^2 committed after N+1 busy cycles.
    function automatic logic [2*W-1:0] model_sq(input logic [W-1:0] n);
        return (2*W)'(int'(n) * int'(n));
    endfunction

    // Called at a falling edge with ready_o high. Runs one operation and
    // checks latency, result, hold behaviour and the done pulse. With poke
    // set, start_i is pulsed and valor_i scrambled during CALC.
    task automatic run_op(input logic [W-1:0] n, input logic [2*W-1:0] exp_sq,
                          input int exp_busy, input bit poke, input string tag);
        int busy = 0;
        int held_ok = 1;
        int early_done = 0;
        start_i = 1'b1;
        valor_i = n;
        @(negedge clk);
        start_i = 1'b0;
        valor_i = W'($urandom);
        while (!ready_o && busy < 2000) begin
            busy++;
            if (square_o !== last_sq) held_ok = 0;
            if (done_o) early_done++;
            if (poke) begin
                start_i = (busy % 3 == 1);
                valor_i = (busy % 2 == 0) ? W'(7) : W'($urandom);
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        check({tag, " busy"}, busy, exp_busy);
        check({tag, " square"}, 32'(square_o), 32'(exp_sq));
        check({tag, " done"}, 32'(done_o), 1);
        check({tag, " held"}, held_ok, 1);
        check({tag, " no early done"}, early_done, 0);
        last_sq = exp_sq;
        @(negedge clk);
        check({tag, " done drop"}, 32'(done_o), 0);
        check({tag, " ready idle"}, 32'(ready_o), 1);
    endtask

    initial begin
        int t1, t2, k, held_ok;
        tbl[0] = '{n: 8'd0,   sq: 16'd0,     busy: 1};
        tbl[1] = '{n: 8'd1,   sq: 16'd1,     busy: 2};
        tbl[2] = '{n: 8'd13,  sq: 16'd169,   busy: 14};
        tbl[3] = '{n: 8'd255, sq: 16'd65025, busy: 256};
        tbl[4] = '{n: 8'd2,   sq: 16'd4,     busy: 3};
        tbl[5] = '{n: 8'd128, sq: 16'd16384, busy: 129};

        // Reset asserted between edges
        #2 rst = 1'b1;
        #1;
        check("reset ready", 32'(ready_o), 1);
        check("reset done", 32'(done_o), 0);
        check("reset square", 32'(square_o), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle ready", 32'(ready_o), 1);
        check("idle done", 32'(done_o), 0);
        check("idle square", 32'(square_o), 0);

        // Table vectors
        for (int i = 0; i < 6; i++)
            run_op(tbl[i].n, tbl[i].sq, tbl[i].busy, 1'b0, $sformatf("vec%0d", i));

        // Busy protection: start pulses and operand changes during CALC
        run_op(8'd20, 16'd400, 21, 1'b1, "busy_prot");

        // Back-to-back with start held high: 3 then 4
        start_i = 1'b1;
        valor_i = 8'd3;
        @(negedge clk);
        valor_i = 8'd4;
        k = 0;
        held_ok = 1;
        while (!done_o && k < 2000) begin
            if (square_o !== last_sq) held_ok = 0;
            k++;
            @(negedge clk);
        end
        t1 = cyc;
        check("b2b first", 32'(square_o), 32'(model_sq(8'd3)));
        check("b2b first held", held_ok, 1);
        last_sq = model_sq(8'd3);
        @(negedge clk);
        start_i = 1'b0;
        check("b2b second accepted", 32'(ready_o), 0);
        k = 0;
        held_ok = 1;
        while (!done_o && k < 2000) begin
            if (square_o !== last_sq) held_ok = 0;
            k++;
            @(negedge clk);
        end
        t2 = cyc;
        check("b2b second", 32'(square_o), 32'(model_sq(8'd4)));
        check("b2b second held", held_ok, 1);
        check("b2b spacing", t2 - t1, 4 + 2);
        last_sq = model_sq(8'd4);
        @(negedge clk);
        check("b2b idle", 32'(ready_o), 1);

        // Mid-operation reset
        start_i = 1'b1;
        valor_i = 8'd100;
        @(negedge clk);
        start_i = 1'b0;
        repeat (29) @(negedge clk);
        check("midrst busy", 32'(ready_o), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst square", 32'(square_o), 0);
        check("midrst ready", 32'(ready_o), 1);
        check("midrst done", 32'(done_o), 0);
        @(negedge clk);
        rst = 1'b0;
        last_sq = '0;
        @(negedge clk);
        run_op(8'd6, 16'd36, 7, 1'b0, "after_rst");

        // Random operands against the model
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] n;
            n = W'($urandom_range(0, 80));
            run_op(n, model_sq(n), int'(n) + 1, ($urandom_range(0, 1) == 1), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
